gray_filter_rtl: RTL
====================

GRAY_FILTER_RTL -- requirements
Module: gray_filter_rtl

Interface
REQ-001 SHALL expose `ap_clk` as an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL expose `ap_rst` as an input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL expose `ap_start` as an input, 1 bit: request to process one pixel, level-sensitive.
REQ-004 SHALL expose `red`, `green` and `blue` as inputs, 8 bits each: pixel channels, sampled only on the accept edge.
REQ-005 SHALL expose `ap_ready` as an output, 1 bit: high in the cycle the inputs are accepted.
REQ-006 SHALL expose `ap_done` as an output, 1 bit: one-cycle pulse marking `ap_return` as valid.
REQ-007 SHALL expose `ap_idle` as an output, 1 bit: high while no pixel is in flight.
REQ-008 SHALL expose `ap_return` as an output, 8 bits: grayscale result.

Function
REQ-009 SHALL implement the ap_ctrl_hs responder side, plug-compatible with the HLS grayscale core, with no parameters.
REQ-010 SHALL use a four-state FSM: IDLE, MUL, ADD, OUT.
REQ-011 In IDLE with ap_start=1: ap_ready=1 (combinational), red/green/blue registered on that edge, next state MUL.
REQ-012 In IDLE with ap_start=0: remain in IDLE.
REQ-013 MUL SHALL register the products 77*R, 150*G and 29*B, each 16 bits wide; next state ADD.
REQ-014 ADD SHALL register the unsigned 16-bit sum of the three products (no overflow possible, max 65280, or 65408 with rounding); next state OUT.
REQ-015 OUT SHALL assert ap_done=1 and load ap_return with sum[15:8]; next state IDLE unconditionally.
REQ-016 Latency SHALL be fixed: ap_done high exactly 3 cycles after the accept edge.
REQ-017 Throughput with ap_start held high SHALL be one pixel per 4 cycles: accepts 4 cycles apart.
REQ-018 ap_start while in MUL, ADD or OUT SHALL be ignored: ap_ready=0, inputs not sampled.
REQ-019 Input changes after the accept edge SHALL NOT affect the in-flight result.
REQ-020 ap_idle SHALL be 1 only in IDLE; ap_ready SHALL never be 1 outside IDLE.
REQ-021 ap_return SHALL hold its last value until the next OUT state; ap_done SHALL be a registered one-cycle pulse.
REQ-022 ap_start dropping after accept SHALL NOT abort the operation.

Reset
REQ-023 On assertion of ap_rst, the design SHALL immediately (asynchronously) go to: state IDLE, ap_done=0, ap_return=0, all pipeline registers 0.
REQ-024 While ap_rst=1: ap_idle=1 and ap_ready=0 regardless of ap_start.
REQ-025 Reset mid-operation SHALL discard the in-flight pixel with no ap_done pulse.
REQ-026 The first accept after reset SHALL be possible on the first rising edge after deassertion if ap_start=1.

Configuration
REQ-027 With macro GRAY_FILTER_ROUND_EN defined: ADD SHALL add the constant 128 to the sum (round to nearest).
REQ-028 Without GRAY_FILTER_ROUND_EN: pure truncation (sum[15:8]); latency and handshake SHALL be identical in both builds.

Structure
REQ-029 The shared package gray_pkg SHALL hold: coefficient constants (77, 150, 29), the rounding constant 128, the pixel width (8), the product/sum width (16), and the FSM state enum.
REQ-030 The arithmetic datapath (MUL and ADD register stages plus rounding) SHALL be one sub-module, gray_dot3.
REQ-031 The FSM and handshake SHALL remain in the top level.

Verification
REQ-032 Accept (255,255,255) -> ap_done 3 cycles later with ap_return=255, in both builds.
REQ-033 Accept (100,50,200) -> ap_return=82 in both builds; accept (0,1,0) -> 0 without rounding, 1 with GRAY_FILTER_ROUND_EN.
REQ-034 ap_start held high for 12 cycles, inputs changed every cycle -> exactly 3 ap_ready pulses 4 cycles apart; each result matches the inputs sampled at its accept edge.
REQ-035 ap_start pulsed for one cycle during ADD -> ignored: no ap_ready, single ap_done, ap_idle back to 1 after OUT.
REQ-036 ap_rst asserted asynchronously in state ADD -> outputs reset immediately, no ap_done follows, ap_return=0; the next accept after release completes normally.
REQ-037 Idle for 20 cycles after a result of 82 -> ap_return stays 82, ap_done stays 0, ap_idle stays 1.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants, widths and FSM encoding for the grayscale filter.
package gray_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned COEF_R  = 77;
  localparam int unsigned COEF_G  = 150;
  localparam int unsigned COEF_B  = 29;
  localparam int unsigned ROUND_C = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/gray_dot3.sv
// Two-stage weighted dot product (R,G,B) -> 16-bit luma sum, top byte exported.
// Define GRAY_FILTER_ROUND_EN to add a half-LSB bias before truncation.
module gray_dot3
  import gray_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mul_en_i,
  input  logic             add_en_i,
  input  logic [PIX_W-1:0] red_i,
  input  logic [PIX_W-1:0] green_i,
  input  logic [PIX_W-1:0] blue_i,
  output logic [PIX_W-1:0] gray_o
);

`ifdef GRAY_FILTER_ROUND_EN
  localparam logic [ACC_W-1:0] BIAS = ACC_W'(ROUND_C);
`else
  localparam logic [ACC_W-1:0] BIAS = '0;
`endif

  logic [ACC_W-1:0] prod_r_q, prod_r_d;
  logic [ACC_W-1:0] prod_g_q, prod_g_d;
  logic [ACC_W-1:0] prod_b_q, prod_b_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             unused_sum_lsb;

  // Worst case 65280 (+128) fits in 16 bits, so no carry-out is needed.
  always_comb begin
    prod_r_d = ACC_W'(COEF_R) * ACC_W'(red_i);
    prod_g_d = ACC_W'(COEF_G) * ACC_W'(green_i);
    prod_b_d = ACC_W'(COEF_B) * ACC_W'(blue_i);
    sum_d    = prod_r_q + prod_g_q + prod_b_q + BIAS;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
      sum_q    <= '0;
    end else begin
      if (mul_en_i) begin
        prod_r_q <= prod_r_d;
        prod_g_q <= prod_g_d;
        prod_b_q <= prod_b_d;
      end
      if (add_en_i) begin
        sum_q <= sum_d;
      end
    end
  end

  assign gray_o         = sum_q[ACC_W-1 -: PIX_W];
  assign unused_sum_lsb = ^sum_q[ACC_W-PIX_W-1:0];

endmodule

// File: rtl/gray_filter_rtl.sv
// ap_ctrl_hs grayscale pixel core: IDLE -> MUL -> ADD -> OUT, one pixel per 4 cycles.
// Build option: GRAY_FILTER_ROUND_EN selects round-to-nearest in gray_dot3.
module gray_filter_rtl
  import gray_pkg::*;
(
  input  logic       ap_clk,
  input  logic       ap_rst,
  input  logic       ap_start,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic       ap_ready,
  output logic       ap_done,
  output logic       ap_idle,
  output logic [7:0] ap_return
);

  state_t           state_q, state_d;
  logic [PIX_W-1:0] red_q, green_q, blue_q;
  logic [PIX_W-1:0] ret_d;
  logic [PIX_W-1:0] gray;
  logic             done_d;
  logic             accept;
  logic             mul_en;
  logic             add_en;

  // Next state, stage enables and handshake; ap_ready is gated off during reset.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    ret_d   = ap_return;
    accept  = 1'b0;
    mul_en  = 1'b0;
    add_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ap_start && !ap_rst) begin
          accept  = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        mul_en  = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        add_en  = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        done_d  = 1'b1;
        ret_d   = gray;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q   <= IDLE;
      ap_done   <= 1'b0;
      ap_return <= '0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
    end else begin
      state_q   <= state_d;
      ap_done   <= done_d;
      ap_return <= ret_d;
      if (accept) begin
        red_q   <= red;
        green_q <= green;
        blue_q  <= blue;
      end
    end
  end

  assign ap_ready = accept;
  assign ap_idle  = (state_q == IDLE);

  gray_dot3 u_dot3 (
    .clk_i    (ap_clk),
    .rst_i    (ap_rst),
    .mul_en_i (mul_en),
    .add_en_i (add_en),
    .red_i    (red_q),
    .green_i  (green_q),
    .blue_i   (blue_q),
    .gray_o   (gray)
  );

endmodule
